store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
Store-path companion to the CPU's load-side sign/zero extension. It takes a 32-bit register value, narrows it to the requested byte or halfword, and places it in the correct lane of a memory word. The data memory has no byte enables, so sub-word stores are done as a read-modify-write sequence. The block sits between the MEM stage and the data memory and stalls the pipeline through a valid/ready handshake.

Parameters:
ADDR_W, 32, width of the byte address and of mem_addr.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_addr  in  ADDR_W  byte address of the store
req_data  in  32  register value; low bits are stored
req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
done  out  1  one-cycle pulse when the request completes
misaligned  out  1  valid with done; the request was rejected and memory was not written
mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2], 2'b00}
mem_rd  out  1  read strobe, held until mem_rvalid
mem_rdata  in  32  read data
mem_rvalid  in  1  read data valid
mem_wr  out  1  write strobe, held until mem_wack
mem_wdata  out  32  merged write word
mem_wack  in  1  write accepted

Behaviour:
- Reset (async, rst_n=0) clears all of the following:
  - state goes to IDLE
  - req_ready=1 once in IDLE; done=0, misaligned=0
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0
  - internal latches are cleared
  - an access in progress is abandoned and its strobes drop immediately.
- States are IDLE, READ, WRITE, DONE.
- IDLE: a request is accepted when req_valid && req_ready. On acceptance the block latches addr, data and size.
- Alignment check in the accept cycle:
  - half requires addr[0]=0
  - word requires addr[1:0]=0
  - size 11 is always an error
- Transitions out of IDLE:
  - Error: go to DONE with misaligned=1. No memory strobe is asserted.
  - Word, aligned: go to WRITE with mem_wdata=req_data.
  - Byte or half, aligned: go to READ.
- READ:
  - mem_rd=1 and mem_addr are held stable until mem_rvalid.
  - On mem_rvalid, the block merges mem_rdata with the narrowed data, registers the result into mem_wdata and goes to WRITE.
  - Lanes are little-endian. A byte with addr[1:0]=k replaces bits [8k+7:8k]; all other bits come from mem_rdata. A half with addr[1]=h replaces bits [16h+15:16h].
- WRITE: mem_wr=1; mem_addr and mem_wdata are held stable until mem_wack. On mem_wack, go to DONE.
- DONE: done=1 for exactly one cycle, with misaligned set as latched. Then go to IDLE.
- Rules that apply in every state:
  - mem_rd and mem_wr are never high together.
  - mem_rvalid is ignored outside READ; mem_wack is ignored outside WRITE.
  - req_ready is 0 in READ, WRITE and DONE, so no new request can be accepted back-to-back in the DONE cycle.
  - Bits of req_data above the store size are ignored.
- Latency, with acceptance at cycle N and zero-wait memory (rvalid and wack in the same cycle as the strobe):
  - word: mem_wr at N+1, done at N+2
  - byte/half: mem_rd at N+1, mem_wr at N+2, done at N+3
  - misaligned: done at N+1
- All outputs are registered.

Test Plan:
- Word store: addr=0x100, data=0xDEADBEEF, size=10 -> mem_wr with mem_addr=0x100, mem_wdata=0xDEADBEEF; no mem_rd; done at N+2; misaligned=0.
- Byte store: addr=0x203, data=0x123456AB, size=00, memory word 0x11223344 -> mem_rd at 0x200, then mem_wr with 0xAB223344; done at N+3.
- Half store, upper lane: addr=0x302, data=0xFFFFCAFE, size=01, memory 0x00000000 -> mem_wdata=0xCAFE0000. Repeat with addr=0x300 -> mem_wdata=0x0000CAFE.
- Misaligned requests: half at 0x101, word at 0x102, and size=11 at 0x100 -> each gives done=misaligned=1 at N+1, with mem_rd and mem_wr never asserted.
- Wait states: hold mem_rvalid low for 3 cycles and mem_wack low for 2 cycles -> mem_rd, mem_wr, mem_addr and mem_wdata stay stable throughout; a stray mem_wack during READ is ignored; req_ready stays 0 until after done.
- Reset mid-operation: assert rst_n=0 while mem_wr=1 -> mem_wr drops without waiting for a clock; no done pulse; req_ready=1 after release; the next byte store completes correctly.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Sub-word store path: narrows a register value to byte/half/word and merges it
// into the addressed memory word via read-modify-write (memory has no byte enables).
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic [31:0]       r_data;

    logic              w_accept;
    logic              w_err;
    logic [31:0]       w_merged;
    logic              w_req_ready;
    logic              w_done;
    logic              w_misaligned;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;

    assign w_accept = req_valid && req_ready && (r_state == S_IDLE);

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_HALF: w_err = req_addr[0];
            SZ_WORD: w_err = (req_addr[1:0] != 2'b00);
            SZ_BYTE: w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
    end

    // Only the low byte/half of the latched data is used, so upper bits are ignored.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SZ_BYTE) begin
            w_merged[8*r_lane +: 8] = r_data[7:0];
        end else begin
            w_merged[16*r_lane[1] +: 16] = r_data[15:0];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lane     <= '0;
            r_size     <= '0;
            r_data     <= '0;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            r_state    <= w_next;
            req_ready  <= w_req_ready;
            done       <= w_done;
            misaligned <= w_misaligned;
            mem_rd     <= w_mem_rd;
            mem_wr     <= w_mem_wr;
            mem_addr   <= w_mem_addr;
            mem_wdata  <= w_mem_wdata;
            if (w_accept) begin
                r_lane <= req_addr[1:0];
                r_size <= req_size;
                r_data <= req_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)                   w_next = S_DONE;
                    else if (req_size == SZ_WORD) w_next = S_WRITE;
                    else                         w_next = S_READ;
                end
            end
            S_READ:  if (mem_rvalid) w_next = S_WRITE;
            S_WRITE: if (mem_wack)   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        w_req_ready  = (w_next == S_IDLE);
        w_done       = (w_next == S_DONE);
        w_misaligned = w_accept && w_err;
        w_mem_rd     = (w_next == S_READ);
        w_mem_wr     = (w_next == S_WRITE);
        w_mem_addr   = mem_addr;
        w_mem_wdata  = mem_wdata;
        if (w_accept) begin
            w_mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
            if (!w_err && req_size == SZ_WORD) begin
                w_mem_wdata = req_data;
            end
        end
        if (r_state == S_READ && mem_rvalid) begin
            w_mem_wdata = w_merged;
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized bench for store_narrow_unit with a behavioural memory and store model.
module tb_store_narrow_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [1:0]    req_size = '0;
    logic          done;
    logic          misaligned;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic          mem_wack = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];

    store_narrow_unit #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] s);
        int unsigned sh;
        logic [31:0] mask;
        if (s == 2'd2) return d;
        if (s == 2'd0) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // Call with time just after a rising edge; returns at the same phase.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                            input int rw, input int ww, input bit stray, input bit abort,
                            output logic [31:0] wdata_seen);
        logic [31:0] wa;
        logic [31:0] expv;
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        bit err, sub, overlap, unstable, early_ready, mis_seen;
        int cyc, rd_first, wr_first, done_cyc, rd_n, wr_n, exp_lat;
        wa   = {addr[31:2], 2'b00};
        err  = ref_err(addr, size);
        sub  = !err && size != 2'd2;
        expv = '0;
        if (!err) expv = ref_store(sub ? rdmem(wa) : 32'h0, addr, data, size);
        wdata_seen = 'x;
        hold_addr = '0; hold_wdata = '0;
        overlap = 0; unstable = 0; early_ready = 0; mis_seen = 0;
        cyc = 0; rd_first = -1; wr_first = -1; done_cyc = -1; rd_n = 0; wr_n = 0;

        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
        while (done_cyc < 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_data  = $urandom;
                req_size  = 2'($urandom);
            end
            mem_rvalid = 1'b0;
            mem_wack   = 1'b0;
            if (mem_rd && mem_wr) overlap = 1;
            if (!done && req_ready) early_ready = 1;
            if (mem_rd) begin
                if (rd_first < 0) begin rd_first = cyc; hold_addr = mem_addr; end
                else if (mem_addr !== hold_addr) unstable = 1;
                rd_n++;
                if (rd_n > rw) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdmem(mem_addr);
                end else begin
                    mem_rdata = $urandom;
                    if (stray) mem_wack = 1'b1;
                end
            end
            if (mem_wr) begin
                if (abort) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_wr_drop", {31'd0, mem_wr}, 32'd0);
                    check("rst_rd_low", {31'd0, mem_rd}, 32'd0);
                    check("rst_done_low", {31'd0, done}, 32'd0);
                    req_valid = 1'b0; mem_wack = 1'b0; mem_rvalid = 1'b0;
                    @(posedge clk); #3;
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    check("rst_ready_after", {31'd0, req_ready}, 32'd1);
                    check("rst_no_done", {31'd0, done}, 32'd0);
                    return;
                end
                if (wr_first < 0) begin wr_first = cyc; hold_addr = mem_addr; hold_wdata = mem_wdata; end
                else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata) unstable = 1;
                wr_n++;
                if (wr_n > ww) begin
                    mem_wack   = 1'b1;
                    wdata_seen = mem_wdata;
                end
            end
            if (done) begin
                done_cyc = cyc;
                mis_seen = misaligned;
            end
        end
        req_valid = 1'b0; mem_rvalid = 1'b0; mem_wack = 1'b0;

        exp_lat = err ? 1 : (size == 2'd2 ? 2 + ww : 3 + rw + ww);
        check("done_latency", 32'(done_cyc), 32'(exp_lat));
        check("misaligned", {31'd0, mis_seen}, {31'd0, err});
        check("rd_first", 32'(rd_first), sub ? 32'd1 : 32'hFFFF_FFFF);
        check("wr_first", 32'(wr_first), err ? 32'hFFFF_FFFF : (size == 2'd2 ? 32'd1 : 32'(2 + rw)));
        check("rd_wr_overlap", {31'd0, overlap}, 32'd0);
        check("strobe_stable", {31'd0, unstable}, 32'd0);
        check("ready_while_busy", {31'd0, early_ready}, 32'd0);
        if (!err) begin
            check("mem_addr", hold_addr, wa);
            check("wdata", wdata_seen, expv);
            mem[wa] = expv;
        end
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        do_store(32'h100, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, w);
        check("dir_word", w, 32'hDEADBEEF);
        mem[32'h200] = 32'h11223344;
        do_store(32'h203, 32'h123456AB, 2'd0, 0, 0, 0, 0, w);
        check("dir_byte", w, 32'hAB223344);
        mem[32'h300] = 32'h0;
        do_store(32'h302, 32'hFFFFCAFE, 2'd1, 0, 0, 0, 0, w);
        check("dir_half_hi", w, 32'hCAFE0000);
        mem[32'h300] = 32'h0;
        do_store(32'h300, 32'hFFFFCAFE, 2'd1, 0, 0, 0, 0, w);
        check("dir_half_lo", w, 32'h0000CAFE);

        do_store(32'h101, 32'h1, 2'd1, 0, 0, 0, 0, w);
        do_store(32'h102, 32'h2, 2'd2, 0, 0, 0, 0, w);
        do_store(32'h100, 32'h3, 2'd3, 0, 0, 0, 0, w);

        do_store(32'h405, $urandom, 2'd0, 3, 2, 1, 0, w);

        do_store(32'h500, 32'h55, 2'd0, 0, 1, 0, 1, w);
        mem[32'h500] = 32'hA5A5A5A5;
        do_store(32'h501, 32'h123477C3, 2'd0, 0, 0, 0, 0, w);
        check("after_rst_byte", w, 32'hA5A5C3A5);

        for (int i = 0; i < 40; i++) begin
            do_store(32'h1000 + $urandom_range(0, 31), $urandom, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
